// File: rtl/irq_dispatch.sv
// Interrupt dispatcher: latches the winning {group, channel} and runs the request/ack/eoi handshake with a request timeout.
// Optional preemption by a higher-priority group while requesting: define IRQ_DISPATCH_PREEMPT_EN.
module irq_dispatch #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pa,
    input  logic       pb,
    input  logic       pc,
    input  logic [2:0] chan,
    input  logic       irq_ack,
    input  logic       irq_eoi,
    input  logic       flag_clr,
    output logic       irq_req,
    output logic [4:0] irq_vector,
    output logic       in_service,
    output logic       timeout_flag
);

    localparam int unsigned GRP_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [GRP_W-1:0] in_grp;
    logic             in_valid;

    // Group encoding of the upstream flags; A outranks B outranks C.
    always_comb begin
        in_valid = pa | pb | pc;
        in_grp   = 2'b00;
        if (pa)
            in_grp = 2'b00;
        else if (pb)
            in_grp = 2'b01;
        else if (pc)
            in_grp = 2'b10;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            irq_req      <= 1'b0;
            irq_vector   <= '0;
            in_service   <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            // A timeout set later in this block overrides a same-cycle clear.
            if (flag_clr)
                timeout_flag <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        irq_vector <= {in_grp, chan};
                        tmo_cnt    <= '0;
                        irq_req    <= 1'b1;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    if (irq_ack) begin
                        irq_req    <= 1'b0;
                        in_service <= 1'b1;
                        state      <= SERVICE;
                    end
`ifdef IRQ_DISPATCH_PREEMPT_EN
                    else if (in_valid && (in_grp < irq_vector[4:3])) begin
                        irq_vector <= {in_grp, chan};
                        tmo_cnt    <= '0;
                    end
`endif
                    else if (tmo_cnt == CNT_LAST) begin
                        irq_req      <= 1'b0;
                        timeout_flag <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                SERVICE: begin
                    if (irq_eoi) begin
                        in_service <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    irq_req    <= 1'b0;
                    in_service <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule
